// File: rtl/sar_search_4bit.sv
// ---------------------------------------------------------------------------
// SarSearch4Bit : successive-approximation search for a 4-bit target value.
// Drives a trial value into an external magnitude comparator and walks the
// bits from MSB to LSB. It stops early on equality and reports invalid
// comparator flag combinations through err.
// ---------------------------------------------------------------------------
module sar_search_4bit #(
   parameter int SETTLE = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       cmp_gt,
   input  logic       cmp_eq,
   input  logic       cmp_lt,
   output logic [3:0] trial,
   output logic       busy,
   output logic       done,
   output logic [3:0] result,
   output logic [2:0] steps,
   output logic       err
);

   typedef enum logic [1:0] {
      IDLE,
      PROBE,
      SETTLE_WAIT,
      FINISH
   } state_t;

   // The wait counter is loaded with SETTLE-1, so the flags are sampled when
   // it reaches zero. With SETTLE=0 the wait state is never entered.
   localparam logic [1:0] SETTLE_LAST = (SETTLE > 0) ? 2'(SETTLE - 1) : 2'd0;

   state_t     state_q, state_d;
   logic [3:0] acc_q, acc_d;
   logic [1:0] idx_q, idx_d;
   logic [3:0] trial_q, trial_d;
   logic [3:0] result_q, result_d;
   logic [2:0] steps_q, steps_d;
   logic       err_q, err_d;
   logic [1:0] wait_q, wait_d;

   logic       sampleNow;
   logic [3:0] accNew;
   logic [1:0] idxNew;

   // State and datapath registers.
   // Reset is asynchronous so an abandoned search clears immediately,
   // without waiting for a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         acc_q    <= 4'd0;
         idx_q    <= 2'd0;
         trial_q  <= 4'd0;
         result_q <= 4'd0;
         steps_q  <= 3'd0;
         err_q    <= 1'b0;
         wait_q   <= 2'd0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         trial_q  <= trial_d;
         result_q <= result_d;
         steps_q  <= steps_d;
         err_q    <= err_d;
         wait_q   <= wait_d;
      end
   end

   // Next-state logic.
   // Each trial is held for one PROBE cycle plus SETTLE wait cycles.
   // The comparator flags are consumed only in the last cycle of that window.
   // After the update rule is applied, the search either probes the next bit
   // or lands in FINISH, which is the single done cycle.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      trial_d   = trial_q;
      result_d  = result_q;
      steps_d   = steps_q;
      err_d     = err_q;
      wait_d    = wait_q;
      sampleNow = 1'b0;
      accNew    = acc_q;
      idxNew    = idx_q;

      case (state_q)
         IDLE, FINISH: begin
            state_d = IDLE;
            trial_d = 4'd0;
            if (start) begin
               acc_d   = 4'd0;
               idx_d   = 2'd3;
               trial_d = 4'b1000;
               steps_d = 3'd0;
               err_d   = 1'b0;
               wait_d  = 2'd0;
               state_d = PROBE;
            end
         end
         PROBE: begin
            if (SETTLE > 0) begin
               state_d = SETTLE_WAIT;
               wait_d  = SETTLE_LAST;
            end else begin
               sampleNow = 1'b1;
            end
         end
         SETTLE_WAIT: begin
            if (wait_q == 2'd0) begin
               sampleNow = 1'b1;
            end else begin
               wait_d = wait_q - 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (sampleNow) begin
         steps_d = steps_q + 3'd1;
         case ({cmp_gt, cmp_eq, cmp_lt})
            3'b010: begin
               result_d = trial_q;
               trial_d  = 4'd0;
               state_d  = FINISH;
            end
            3'b100, 3'b001: begin
               if (cmp_gt) begin
                  accNew = trial_q;
               end
               acc_d = accNew;
               if (idx_q != 2'd0) begin
                  idxNew  = idx_q - 2'd1;
                  idx_d   = idxNew;
                  trial_d = accNew | (4'b0001 << idxNew);
                  state_d = PROBE;
               end else begin
                  result_d = accNew;
                  trial_d  = 4'd0;
                  state_d  = FINISH;
               end
            end
            default: begin
               err_d    = 1'b1;
               result_d = acc_q;
               trial_d  = 4'd0;
               state_d  = FINISH;
            end
         endcase
      end
   end

   assign trial  = trial_q;
   assign busy   = (state_q == PROBE) || (state_q == SETTLE_WAIT);
   assign done   = (state_q == FINISH);
   assign result = result_q;
   assign steps  = steps_q;
   assign err    = err_q;

endmodule

// File: tb/tb_sar_search_4bit.sv
// ---------------------------------------------------------------------------
// TbSarSearch4Bit : bench for two instances of the search block, one with
// SETTLE=0 and one with SETTLE=2. Both instances share the same target and
// are driven by a behavioural comparator.
// ---------------------------------------------------------------------------
module tb_sar_search_4bit;

   localparam int SET [2] = '{0, 2};

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [3:0]      target;
   logic            forceBad;

   logic [1:0]      gtW, eqW, ltW, busyW, doneW, errW;
   logic [1:0][3:0] trialW, resultW;
   logic [1:0][2:0] stepsW;

   int checks = 0;
   int errors = 0;

   // Model state per instance.
   // mPlan packs {err, result[3:0], n[2:0], trials[15:0]}.
   int          mK     [2] = '{0, 0};
   logic [23:0] mPlan  [2] = '{24'd0, 24'd0};
   int          hRes   [2] = '{0, 0};
   int          hSteps [2] = '{0, 0};
   int          hErr   [2] = '{0, 0};

   logic [3:0] seq0[$];
   logic [3:0] seq2[$];
   int doneAt0;
   int doneAt2;

   always #5 clk = ~clk;

   // Behavioural comparator.
   // forceBad drives an illegal gt+lt combination.
   assign gtW[0] = forceBad | (target > trialW[0]);
   assign eqW[0] = ~forceBad & (target == trialW[0]);
   assign ltW[0] = forceBad | (target < trialW[0]);
   assign gtW[1] = forceBad | (target > trialW[1]);
   assign eqW[1] = ~forceBad & (target == trialW[1]);
   assign ltW[1] = forceBad | (target < trialW[1]);

   sar_search_4bit #(.SETTLE(0)) dutS0 (
      .clk(clk), .rst(rst), .start(start),
      .cmp_gt(gtW[0]), .cmp_eq(eqW[0]), .cmp_lt(ltW[0]),
      .trial(trialW[0]), .busy(busyW[0]), .done(doneW[0]),
      .result(resultW[0]), .steps(stepsW[0]), .err(errW[0])
   );

   sar_search_4bit #(.SETTLE(2)) dutS2 (
      .clk(clk), .rst(rst), .start(start),
      .cmp_gt(gtW[1]), .cmp_eq(eqW[1]), .cmp_lt(ltW[1]),
      .trial(trialW[1]), .busy(busyW[1]), .done(doneW[1]),
      .result(resultW[1]), .steps(stepsW[1]), .err(errW[1])
   );

   // Binary search written as plain arithmetic.
   // Each probe adds the next power of two onto the value known to be <= target.
   function automatic logic [23:0] planSearch(input logic [3:0] tgt, input logic bad);
      logic [15:0] tr = 16'd0;
      int n = 0;
      int acc = 0;
      logic [3:0] res = 4'd0;
      logic e = 1'b0;
      bit found = 1'b0;
      if (bad) begin
         tr[3:0] = 4'd8;
         n = 1;
         e = 1'b1;
      end else begin
         for (int b = 3; b >= 0; b--) begin
            if (!found) begin
               int t;
               t = acc + (1 << b);
               tr[4*n +: 4] = 4'(t);
               n++;
               if (t == int'(tgt)) begin
                  res = 4'(t);
                  found = 1'b1;
               end else if (int'(tgt) > t) begin
                  acc = t;
               end
            end
         end
         if (!found) res = 4'(acc);
      end
      return {e, res, 3'(n), tr};
   endfunction

   function automatic int lenOf(input int i);
      return int'(mPlan[i][18:16]) * (SET[i] + 1);
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance the model.
   // k counts cycles since start acceptance; k = L+1 is the done cycle.
   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            mK[i]     <= 0;
            hRes[i]   <= 0;
            hSteps[i] <= 0;
            hErr[i]   <= 0;
         end else begin
            if (mK[i] != 0 && mK[i] == lenOf(i) + 1) begin
               hRes[i]   <= int'(mPlan[i][22:19]);
               hSteps[i] <= int'(mPlan[i][18:16]);
               hErr[i]   <= int'(mPlan[i][23]);
            end
            if (start && !(mK[i] >= 1 && mK[i] <= lenOf(i))) begin
               mPlan[i] <= planSearch(target, forceBad);
               mK[i]    <= 1;
            end else if (mK[i] == 0 || mK[i] == lenOf(i) + 1) begin
               mK[i] <= 0;
            end else begin
               mK[i] <= mK[i] + 1;
            end
         end
      end
   end

   task automatic compareInst(input int i);
      int s;
      int n;
      int len;
      int k;
      int j;
      string pf;
      s   = SET[i];
      n   = int'(mPlan[i][18:16]);
      len = n * (s + 1);
      k   = mK[i];
      pf  = (i == 0) ? "s0." : "s2.";
      if (k == 0) begin
         checkOutput({pf, "trial"}, int'(trialW[i]), 0);
         checkOutput({pf, "busy"}, int'(busyW[i]), 0);
         checkOutput({pf, "done"}, int'(doneW[i]), 0);
         checkOutput({pf, "result"}, int'(resultW[i]), hRes[i]);
         checkOutput({pf, "steps"}, int'(stepsW[i]), hSteps[i]);
         checkOutput({pf, "err"}, int'(errW[i]), hErr[i]);
      end else if (k <= len) begin
         j = (k - 1) / (s + 1);
         checkOutput({pf, "trial"}, int'(trialW[i]), int'(mPlan[i][4*j +: 4]));
         checkOutput({pf, "busy"}, int'(busyW[i]), 1);
         checkOutput({pf, "done"}, int'(doneW[i]), 0);
         checkOutput({pf, "steps"}, int'(stepsW[i]), j);
         checkOutput({pf, "err"}, int'(errW[i]), 0);
      end else begin
         checkOutput({pf, "trial"}, int'(trialW[i]), 0);
         checkOutput({pf, "busy"}, int'(busyW[i]), 0);
         checkOutput({pf, "done"}, int'(doneW[i]), 1);
         checkOutput({pf, "result"}, int'(resultW[i]), int'(mPlan[i][22:19]));
         checkOutput({pf, "steps"}, int'(stepsW[i]), n);
         checkOutput({pf, "err"}, int'(errW[i]), int'(mPlan[i][23]));
      end
   endtask

   // Compare both instances against the model.
   // This runs on every falling edge while reset is low.
   always @(negedge clk) begin
      if (!rst) begin
         compareInst(0);
         compareInst(1);
      end
   end

   // One search.
   // Start is asserted for one rising edge, then the trial sequence and the
   // done cycle are recorded for both instances. extraStartAt re-asserts start
   // in that cycle number (0 disables it).
   task automatic applyStimulus(input logic [3:0] tgt, input logic bad, input int extraStartAt);
      target   = tgt;
      forceBad = bad;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      seq0.delete();
      seq2.delete();
      doneAt0 = 0;
      doneAt2 = 0;
      for (int n = 1; n <= 40 && (doneAt0 == 0 || doneAt2 == 0); n++) begin
         if (n > 1) @(negedge clk);
         start = (n == extraStartAt);
         if (busyW[0]) seq0.push_back(trialW[0]);
         if (busyW[1]) seq2.push_back(trialW[1]);
         if (doneW[0] && doneAt0 == 0) doneAt0 = n;
         if (doneW[1] && doneAt2 == 0) doneAt2 = n;
      end
      start = 1'b0;
      if (doneAt0 == 0 || doneAt2 == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL timeout: done0 at %0d, done2 at %0d, required both nonzero", doneAt0, doneAt2);
      end
   endtask

   // Compare a recorded trial sequence with a packed list of n trials.
   // Each trial is expected rep times in a row.
   task automatic checkSeq(input string name, input int which, input logic [15:0] exp, input int n, input int rep);
      int sz;
      int a;
      sz = (which == 0) ? seq0.size() : seq2.size();
      checkOutput({name, ".len"}, sz, n * rep);
      for (int j = 0; j < n * rep && j < sz; j++) begin
         a = (which == 0) ? int'(seq0[j]) : int'(seq2[j]);
         checkOutput($sformatf("%s[%0d]", name, j), a, int'(exp[4*(j/rep) +: 4]));
      end
   endtask

   task automatic checkAllZero(input string tag);
      for (int i = 0; i < 2; i++) begin
         checkOutput($sformatf("%s.%0d.trial", tag, i), int'(trialW[i]), 0);
         checkOutput($sformatf("%s.%0d.busy", tag, i), int'(busyW[i]), 0);
         checkOutput($sformatf("%s.%0d.done", tag, i), int'(doneW[i]), 0);
         checkOutput($sformatf("%s.%0d.result", tag, i), int'(resultW[i]), 0);
         checkOutput($sformatf("%s.%0d.steps", tag, i), int'(stepsW[i]), 0);
         checkOutput($sformatf("%s.%0d.err", tag, i), int'(errW[i]), 0);
      end
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      target   = 4'd0;
      forceBad = 1'b0;
      repeat (2) @(negedge clk);
      checkAllZero("reset");
      rst = 1'b0;
      @(negedge clk);

      applyStimulus(4'd5, 1'b0, 0);
      checkSeq("t5.seq0", 0, 16'h5648, 4, 1);
      checkOutput("t5.doneAt0", doneAt0, 5);
      checkOutput("t5.doneAt2", doneAt2, 13);
      checkOutput("t5.result", int'(resultW[0]), 5);
      checkOutput("t5.steps", int'(stepsW[0]), 4);
      checkOutput("t5.err", int'(errW[0]), 0);

      applyStimulus(4'd8, 1'b0, 0);
      checkOutput("t8.doneAt0", doneAt0, 2);
      checkOutput("t8.doneAt2", doneAt2, 4);
      checkOutput("t8.result0", int'(resultW[0]), 8);
      checkOutput("t8.steps0", int'(stepsW[0]), 1);

      applyStimulus(4'd0, 1'b0, 0);
      checkSeq("t0.seq0", 0, 16'h1248, 4, 1);
      checkOutput("t0.doneAt0", doneAt0, 5);
      checkOutput("t0.result", int'(resultW[0]), 0);
      checkOutput("t0.steps", int'(stepsW[0]), 4);

      applyStimulus(4'd15, 1'b0, 0);
      checkSeq("t15.seq0", 0, 16'hFEC8, 4, 1);
      checkOutput("t15.result", int'(resultW[0]), 15);
      checkOutput("t15.steps", int'(stepsW[0]), 4);

      applyStimulus(4'd11, 1'b0, 0);
      checkSeq("t11.seq2", 1, 16'hBAC8, 4, 3);
      checkOutput("t11.doneAt2", doneAt2, 13);
      checkOutput("t11.result2", int'(resultW[1]), 11);

      applyStimulus(4'd7, 1'b1, 0);
      checkOutput("bad.doneAt0", doneAt0, 2);
      checkOutput("bad.doneAt2", doneAt2, 4);
      checkOutput("bad.err0", int'(errW[0]), 1);
      checkOutput("bad.err2", int'(errW[1]), 1);
      checkOutput("bad.result0", int'(resultW[0]), 0);
      checkOutput("bad.steps0", int'(stepsW[0]), 1);

      applyStimulus(4'd3, 1'b0, 0);
      checkOutput("t3.err0", int'(errW[0]), 0);
      checkOutput("t3.result0", int'(resultW[0]), 3);
      checkOutput("t3.steps0", int'(stepsW[0]), 4);

      applyStimulus(4'd6, 1'b0, 2);
      checkSeq("busyStart.seq0", 0, 16'h0648, 3, 1);
      checkOutput("busyStart.doneAt0", doneAt0, 4);
      checkOutput("busyStart.doneAt2", doneAt2, 10);
      checkOutput("busyStart.steps0", int'(stepsW[0]), 3);

      // Reset pulsed asynchronously in the middle of a search.
      target = 4'd9;
      start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1 checkAllZero("midRst");
      @(posedge clk);
      @(negedge clk);
      checkOutput("midRst.noDone0", int'(doneW[0]), 0);
      checkOutput("midRst.noDone2", int'(doneW[1]), 0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("afterRst.busy0", int'(busyW[0]), 0);

      applyStimulus(4'd9, 1'b0, 0);
      checkOutput("t9.doneAt0", doneAt0, 5);
      checkOutput("t9.result0", int'(resultW[0]), 9);
      checkOutput("t9.steps0", int'(stepsW[0]), 4);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
